drive_ramp_controller: RTL

- Motion executor on the receiving end of the task manager's `enable_forward` command.
- Converts the level command into a soft-started / soft-stopped PWM drive for the motor stage.
- Duty ramps in fixed steps on each slow `ramp_tick` enable, which comes from a divider instance.
- Reports its state and a one-cycle halt acknowledgement back to the task manager.

---
 rtl/drive_ramp_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/drive_ramp_controller.sv
// drive_ramp_controller
// Turns the enable_forward level command into a PWM motor drive with a
// soft start and a soft stop. The duty moves by RAMP_STEP on each ramp_tick.
// The PWM compare uses a shadow copy of the duty. The shadow is reloaded only
// at the end of a PWM period, so a duty change never cuts a period short.
module drive_ramp_controller #(
  parameter int PWM_BITS  = 8,
  parameter int MAX_DUTY  = 200,
  parameter int RAMP_STEP = 50
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_forward,
  input  logic                ramp_tick,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic [1:0]          drive_state,
  output logic                busy,
  output logic                halted
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RAMP_UP   = 2'd1,
    ST_CRUISE    = 2'd2,
    ST_RAMP_DOWN = 2'd3
  } state_t;

  localparam logic [PWM_BITS-1:0] MAX_DUTY_V = PWM_BITS'(MAX_DUTY);
  localparam logic [PWM_BITS-1:0] STEP_V     = PWM_BITS'(RAMP_STEP);
  localparam logic [PWM_BITS-1:0] CNT_TOP    = '1;

  state_t              state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_active_q, duty_active_d;
  logic [PWM_BITS-1:0] counter_q, counter_d;
  logic                pwm_q, pwm_d;
  logic                halted_q, halted_d;

  logic [PWM_BITS:0]   sum_wide;
  logic [PWM_BITS-1:0] duty_inc;
  logic [PWM_BITS-1:0] duty_dec;

  // Saturating step arithmetic: the sum is one bit wider so it cannot wrap,
  // and the decrement floors at zero.
  always_comb begin
    sum_wide = {1'b0, duty_q} + {1'b0, STEP_V};
    duty_inc = (sum_wide > {1'b0, MAX_DUTY_V}) ? MAX_DUTY_V : sum_wide[PWM_BITS-1:0];
    duty_dec = (duty_q <= STEP_V) ? '0 : (duty_q - STEP_V);
  end

  // Next state and duty. Command changes take priority over a coincident tick.
  always_comb begin
    state_d  = state_q;
    duty_d   = duty_q;
    halted_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable_forward) begin
          state_d = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (!enable_forward) begin
          state_d = ST_RAMP_DOWN;
        end else if (ramp_tick) begin
          duty_d = duty_inc;
          if (duty_inc == MAX_DUTY_V) begin
            state_d = ST_CRUISE;
          end
        end
      end
      ST_CRUISE: begin
        if (!enable_forward) begin
          state_d = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (enable_forward) begin
          state_d = ST_RAMP_UP;
        end else if (ramp_tick) begin
          duty_d = duty_dec;
          if (duty_dec == '0) begin
            state_d  = ST_IDLE;
            halted_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = '0;
      end
    endcase
  end

  // Free-running PWM counter. The shadow duty is reloaded on the last count
  // of the period. The output bit is registered one cycle after the compare.
  always_comb begin
    counter_d     = counter_q + PWM_BITS'(1);
    duty_active_d = (counter_q == CNT_TOP) ? duty_q : duty_active_q;
    pwm_d         = (counter_q < duty_active_q);
  end

  // State, duty and PWM registers. The async reset clears everything,
  // including the output bit, at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      duty_q        <= '0;
      duty_active_q <= '0;
      counter_q     <= '0;
      pwm_q         <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      duty_q        <= duty_d;
      duty_active_q <= duty_active_d;
      counter_q     <= counter_d;
      pwm_q         <= pwm_d;
      halted_q      <= halted_d;
    end
  end

  // Status outputs. busy is decoded from the state register.
  always_comb begin
    pwm_out     = pwm_q;
    duty        = duty_q;
    drive_state = state_q;
    busy        = (state_q != ST_IDLE);
    halted      = halted_q;
  end

endmodule
